// File: rtl/lcd_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_ctrl
// Turns the core's memory-mapped LCD register into HD44780 write cycles
// (8-bit bus, write only). After reset it waits out the LCD power-up time and
// sends a fixed four-command init sequence. Processor writes are queued in a
// small FIFO so that back-to-back stores are not lost while the LCD is busy.
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_lcd_word   [31] display power, [9] request toggle, [8] RS, [7:0] byte
//   o_lcd_data   LCD data bus
//   o_lcd_rs     register select (0 command, 1 data)
//   o_lcd_rw     read/write, always 0 (write)
//   o_lcd_en     enable strobe
//   o_lcd_on     LCD power, registered copy of i_lcd_word[31]
//   o_lcd_status [0] busy, [1] FIFO full, [2] overflow (sticky), [3] init done
//
// Request handshake: the processor has no valid/ready pair. It requests a
// transfer by flipping bit 9 of the word (either direction); every observed
// flip queues one {RS, byte} entry. There is no back-pressure: a flip that
// meets a full FIFO (with no pop in the same cycle) is dropped and the sticky
// overflow bit is raised. Software polls o_lcd_status to avoid that.
// -----------------------------------------------------------------------------
module lcd_ctrl #(
  parameter int P_PWRUP = 750000,
  parameter int P_EN    = 25,
  parameter int P_CMD   = 2000,
  parameter int P_CLR   = 80000,
  parameter int P_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic [31:0] o_lcd_status
);

  localparam int AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int CW = $clog2(P_DEPTH + 1);
  localparam logic [CW-1:0] LP_FULL = CW'(P_DEPTH);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_WAIT
  } state_t;

  // ---------------------------------------------------------------------------
  // Input stage: the word is registered first so nothing on the LCD pins
  // depends combinationally on i_lcd_word; r_prev holds the previous toggle.
  // ---------------------------------------------------------------------------
  logic       r_tog;
  logic       r_prev;
  logic [8:0] r_payload;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tog     <= 1'b0;
      r_prev    <= 1'b0;
      r_payload <= 9'd0;
      o_lcd_on  <= 1'b0;
    end else begin
      r_tog     <= i_lcd_word[9];
      r_prev    <= r_tog;
      r_payload <= i_lcd_word[8:0];
      o_lcd_on  <= i_lcd_word[31];
    end
  end

  // Bits [30:10] carry nothing for this block.
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, i_lcd_word[30:10]};

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic            r_init_done;
  logic [8:0]      r_mem [P_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_accept;

  assign w_push   = r_tog ^ r_prev;
  assign w_pop    = (r_state == S_IDLE) && r_init_done && (r_count != '0);
  assign w_full   = (r_count == LP_FULL);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign w_accept = w_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_accept) r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= r_payload;
  end

  // ---------------------------------------------------------------------------
  // Bus-cycle FSM
  // ---------------------------------------------------------------------------
  logic [31:0] r_cnt;
  logic [2:0]  r_init_idx;   // next init ROM entry to send
  logic [31:0] w_wait_last;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    init_rom = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    init_rom = 8'h0C;  // display on, cursor off
      2'd2:    init_rom = 8'h01;  // clear display
      default: init_rom = 8'h06;  // entry mode: increment, no shift
    endcase
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long settle time.
  assign w_wait_last = (!o_lcd_rs && (o_lcd_data[7:2] == 6'd0)) ?
                       32'(P_CLR - 1) : 32'(P_CMD - 1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_PWRUP;
      r_cnt       <= 32'd0;
      r_init_idx  <= 3'd0;
      r_init_done <= 1'b0;
      o_lcd_data  <= 8'h00;
      o_lcd_rs    <= 1'b0;
      o_lcd_en    <= 1'b0;
    end else begin
      case (r_state)
        S_PWRUP: begin
          if (r_cnt == 32'(P_PWRUP - 1)) begin
            r_cnt      <= 32'd0;
            o_lcd_data <= init_rom(2'd0);
            o_lcd_rs   <= 1'b0;
            r_init_idx <= 3'd1;
            r_state    <= S_SETUP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_IDLE: begin
          r_cnt <= 32'd0;
          if (!r_init_done) begin
            o_lcd_data <= init_rom(r_init_idx[1:0]);
            o_lcd_rs   <= 1'b0;
            r_init_idx <= r_init_idx + 3'd1;
            r_state    <= S_SETUP;
          end else if (r_count != '0) begin
            o_lcd_data <= r_mem[r_rd_ptr][7:0];
            o_lcd_rs   <= r_mem[r_rd_ptr][8];
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == 32'(P_EN - 1)) begin
            r_cnt    <= 32'd0;
            o_lcd_en <= 1'b1;
            r_state  <= S_EN_HI;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_EN_HI: begin
          if (r_cnt == 32'(P_EN - 1)) begin
            r_cnt    <= 32'd0;
            o_lcd_en <= 1'b0;
            r_state  <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_WAIT: begin
          if (r_cnt == w_wait_last) begin
            r_cnt   <= 32'd0;
            r_state <= S_IDLE;
            // Only init entries run before init_done, so index 4 means the
            // last ROM command has just settled.
            if (!r_init_done && (r_init_idx == 3'd4)) r_init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          r_cnt   <= 32'd0;
          r_state <= S_PWRUP;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Status
  // ---------------------------------------------------------------------------
  logic r_busy;
  logic r_full;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy <= 1'b1;
      r_full <= 1'b0;
    end else begin
      r_busy <= (r_state != S_IDLE) || (r_count != '0) || !r_init_done;
      r_full <= w_full;
    end
  end

  assign o_lcd_status = {28'd0, r_init_done, r_ovf, r_full, r_busy};
  assign o_lcd_rw     = 1'b0;

endmodule
